// File: rtl/control_pkg.sv
// Shared encodings and control bundle for the main decoder.
// Optional illegal-encoding flag: CONTROL_ILLEGAL_EN.
package control_pkg;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW_ALT = 6'h25;
  localparam logic [5:0] OP_SW     = 6'h2B;

  localparam logic [5:0] F_JR      = 6'h08;
  localparam logic [5:0] F_SYSCALL = 6'h0C;
  localparam logic [5:0] F_MFHI    = 6'h10;
  localparam logic [5:0] F_MFLO    = 6'h12;
  localparam logic [5:0] F_MULT    = 6'h18;
  localparam logic [5:0] F_DIV     = 6'h1A;
  localparam logic [5:0] F_ADD     = 6'h20;
  localparam logic [5:0] F_SUB     = 6'h22;
  localparam logic [5:0] F_OR      = 6'h25;
  localparam logic [5:0] F_SLT     = 6'h2A;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_RTYPE = 2'b10;
  localparam logic [1:0] ALU_LOGI  = 2'b11;

  typedef struct packed {
    logic [1:0] alu_op;
    logic [5:0] func;
    logic       reg_dst;
    logic       beq;
    logic       bne;
    logic       jmp;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic       lui;
    logic       sys_en;
`ifdef CONTROL_ILLEGAL_EN
    logic       illegal;
`endif
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  function automatic logic rtype_wr(
    input logic [5:0] fn
  );
    return (fn == F_ADD)  || (fn == F_SUB)
        || (fn == F_OR)   || (fn == F_SLT)
        || (fn == F_MFHI) || (fn == F_MFLO);
  endfunction

endpackage

// File: rtl/control_if.sv
// Decoder bus: fetch side drives instr/stall,
// decoder drives the datapath control strobes.
interface control_if;

  logic        stall;
  logic [31:0] instr;
  logic [1:0]  ALUOp;
  logic [5:0]  func;
  logic        RegDST;
  logic        BEQ;
  logic        BNE;
  logic        JMP;
  logic        MemRead;
  logic        MemtoReg;
  logic        MemWrite;
  logic        ALUSrc;
  logic        RegWrite;
  logic        LUI;
  logic        SysEnable;
`ifdef CONTROL_ILLEGAL_EN
  logic        illegal;
`endif

  modport master (
    output stall, instr,
    input  ALUOp, func, RegDST,
           BEQ, BNE, JMP,
           MemRead, MemtoReg, MemWrite,
           ALUSrc, RegWrite, LUI, SysEnable
`ifdef CONTROL_ILLEGAL_EN
           , illegal
`endif
  );

  modport slave (
    input  stall, instr,
    output ALUOp, func, RegDST,
           BEQ, BNE, JMP,
           MemRead, MemtoReg, MemWrite,
           ALUSrc, RegWrite, LUI, SysEnable
`ifdef CONTROL_ILLEGAL_EN
           , illegal
`endif
  );

endinterface

// File: rtl/control_decode.sv
// Combinational instruction decode: instr -> ctrl_t.
// Flags unknown encodings when CONTROL_ILLEGAL_EN is set.
module control_decode
  import control_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_t       ctrl
);

  logic [5:0] op;
  logic [5:0] fn;

  assign op = instr[31:26];
  assign fn = instr[5:0];

  // opcode/funct decode; the all-zero word is a true NOP
  always_comb begin
    ctrl = CTRL_NOP;
    if (instr != 32'h0) begin
      unique case (op)
        OP_RTYPE: begin
          unique case (1'b1)
            rtype_wr(fn): begin
              ctrl.alu_op    = ALU_RTYPE;
              ctrl.func      = fn;
              ctrl.reg_dst   = 1'b1;
              ctrl.reg_write = 1'b1;
            end
            (fn == F_MULT) || (fn == F_DIV): begin
              ctrl.alu_op  = ALU_RTYPE;
              ctrl.func    = fn;
              ctrl.reg_dst = 1'b1;
            end
            (fn == F_JR): begin
              ctrl.alu_op = ALU_RTYPE;
              ctrl.func   = fn;
              ctrl.jmp    = 1'b1;
            end
            (fn == F_SYSCALL): begin
              ctrl.alu_op = ALU_RTYPE;
              ctrl.func   = fn;
              ctrl.sys_en = 1'b1;
            end
            default: begin
`ifdef CONTROL_ILLEGAL_EN
              ctrl.illegal = 1'b1;
`endif
            end
          endcase
        end
        OP_BEQ: begin
          ctrl.beq    = 1'b1;
          ctrl.alu_op = ALU_SUB;
          ctrl.func   = F_SUB;
        end
        OP_BNE: begin
          ctrl.bne    = 1'b1;
          ctrl.alu_op = ALU_SUB;
          ctrl.func   = F_SUB;
        end
        OP_LW: begin
          ctrl.mem_read   = 1'b1;
          ctrl.mem_to_reg = 1'b1;
          ctrl.alu_src    = 1'b1;
          ctrl.reg_write  = 1'b1;
          ctrl.alu_op     = ALU_ADD;
          ctrl.func       = F_ADD;
        end
        OP_SW, OP_SW_ALT: begin
          ctrl.mem_write = 1'b1;
          ctrl.alu_src   = 1'b1;
          ctrl.alu_op    = ALU_ADD;
          ctrl.func      = F_ADD;
        end
        OP_LUI: begin
          ctrl.lui       = 1'b1;
          ctrl.reg_write = 1'b1;
          ctrl.alu_src   = 1'b1;
          ctrl.alu_op    = ALU_LOGI;
          ctrl.func      = F_OR;
        end
        OP_ORI: begin
          ctrl.reg_write = 1'b1;
          ctrl.alu_src   = 1'b1;
          ctrl.alu_op    = ALU_LOGI;
          ctrl.func      = F_OR;
        end
        OP_ADDI: begin
          ctrl.reg_write = 1'b1;
          ctrl.alu_src   = 1'b1;
          ctrl.alu_op    = ALU_ADD;
          ctrl.func      = F_ADD;
        end
        OP_J: begin
          ctrl.jmp = 1'b1;
        end
        OP_JAL: begin
          ctrl.jmp       = 1'b1;
          ctrl.reg_write = 1'b1;
        end
        default: begin
`ifdef CONTROL_ILLEGAL_EN
          ctrl.illegal = 1'b1;
`endif
        end
      endcase
    end
  end

endmodule

// File: rtl/control_unit.sv
// Main decoder with one registered stage and stall hold.
// Optional illegal output: CONTROL_ILLEGAL_EN.
module control_unit
  import control_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  control_if.slave bus
);

  ctrl_t dec;
  ctrl_t q;

  control_decode u_decode (
    .instr (bus.instr),
    .ctrl  (dec)
  );

  // reset beats stall; stall freezes the decoded bundle
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= CTRL_NOP;
    end else if (!bus.stall) begin
      q <= dec;
    end
  end

  assign bus.ALUOp     = q.alu_op;
  assign bus.func      = q.func;
  assign bus.RegDST    = q.reg_dst;
  assign bus.BEQ       = q.beq;
  assign bus.BNE       = q.bne;
  assign bus.JMP       = q.jmp;
  assign bus.MemRead   = q.mem_read;
  assign bus.MemtoReg  = q.mem_to_reg;
  assign bus.MemWrite  = q.mem_write;
  assign bus.ALUSrc    = q.alu_src;
  assign bus.RegWrite  = q.reg_write;
  assign bus.LUI       = q.lui;
  assign bus.SysEnable = q.sys_en;
`ifdef CONTROL_ILLEGAL_EN
  assign bus.illegal   = q.illegal;
`endif

endmodule

// File: tb/tb_control_unit.sv
// Directed-vector bench for control_unit.
// Exercises CONTROL_ILLEGAL_EN checks when defined.
module tb_control_unit;

  logic clk;
  logic reset;

  control_if bus ();

  control_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // flags: RegDST BEQ BNE JMP MemRead MemtoReg
  //        MemWrite ALUSrc RegWrite LUI SysEnable
  typedef struct {
    logic [31:0] instr;
    logic [18:0] exp;
    logic        ill;
  } vec_t;

  int checks = 0;
  int errors = 0;
  vec_t vt[$];

  function automatic logic [18:0] mk(
    input logic [1:0]  a,
    input logic [5:0]  f,
    input logic [10:0] fl
  );
    return {a, f, fl};
  endfunction

  function automatic logic [18:0] got();
    return {bus.ALUOp, bus.func, bus.RegDST,
            bus.BEQ, bus.BNE, bus.JMP,
            bus.MemRead, bus.MemtoReg,
            bus.MemWrite, bus.ALUSrc,
            bus.RegWrite, bus.LUI,
            bus.SysEnable};
  endfunction

  task automatic check(
    input string       name,
    input logic [18:0] exp,
    input logic        ill
  );
    logic [18:0] g;
    g = got();
    checks++;
    if (g !== exp) begin
      errors++;
      $display("FAIL %s got %05h exp %05h",
               name, g, exp);
    end
`ifdef CONTROL_ILLEGAL_EN
    checks++;
    if (bus.illegal !== ill) begin
      errors++;
      $display("FAIL %s illegal got %b exp %b",
               name, bus.illegal, ill);
    end
`else
    if (ill === 1'bx) $display("unreachable");
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [18:0] E_NOP = '0;
  logic [18:0] e_lw;
  logic [18:0] e_beq;

  initial begin
    e_lw  = mk(2'b00, 6'h20, 11'b00001101100);
    e_beq = mk(2'b01, 6'h22, 11'b01000000000);

    vt.push_back('{32'h10000000, e_beq, 1'b0});
    vt.push_back('{32'h14000000,
      mk(2'b01, 6'h22, 11'b00100000000), 1'b0});
    vt.push_back('{32'h08000000,
      mk(2'b00, 6'h00, 11'b00010000000), 1'b0});
    vt.push_back('{32'h0C000000,
      mk(2'b00, 6'h00, 11'b00010000100), 1'b0});
    vt.push_back('{32'h00000008,
      mk(2'b10, 6'h08, 11'b00010000000), 1'b0});
    vt.push_back('{32'h03E00008,
      mk(2'b10, 6'h08, 11'b00010000000), 1'b0});
    vt.push_back('{32'h3C000000,
      mk(2'b11, 6'h25, 11'b00000001110), 1'b0});
    vt.push_back('{32'h34000000,
      mk(2'b11, 6'h25, 11'b00000001100), 1'b0});
    vt.push_back('{32'h20000000,
      mk(2'b00, 6'h20, 11'b00000001100), 1'b0});
    vt.push_back('{32'h94000000,
      mk(2'b00, 6'h20, 11'b00000011000), 1'b0});
    vt.push_back('{32'hAC000000,
      mk(2'b00, 6'h20, 11'b00000011000), 1'b0});
    vt.push_back('{32'h8C12ABCD, e_lw, 1'b0});
    vt.push_back('{32'h00000020,
      mk(2'b10, 6'h20, 11'b10000000100), 1'b0});
    vt.push_back('{32'h00000022,
      mk(2'b10, 6'h22, 11'b10000000100), 1'b0});
    vt.push_back('{32'h00000025,
      mk(2'b10, 6'h25, 11'b10000000100), 1'b0});
    vt.push_back('{32'h0022182A,
      mk(2'b10, 6'h2A, 11'b10000000100), 1'b0});
    vt.push_back('{32'h00000010,
      mk(2'b10, 6'h10, 11'b10000000100), 1'b0});
    vt.push_back('{32'h00000012,
      mk(2'b10, 6'h12, 11'b10000000100), 1'b0});
    vt.push_back('{32'h00000018,
      mk(2'b10, 6'h18, 11'b10000000000), 1'b0});
    vt.push_back('{32'h0000001A,
      mk(2'b10, 6'h1A, 11'b10000000000), 1'b0});
    vt.push_back('{32'h0000000C,
      mk(2'b10, 6'h0C, 11'b00000000001), 1'b0});
    vt.push_back('{32'h00000000, E_NOP, 1'b0});
    vt.push_back('{32'hFC000000, E_NOP, 1'b1});
    vt.push_back('{32'h0000003F, E_NOP, 1'b1});
    vt.push_back('{32'h00221800, E_NOP, 1'b1});
    vt.push_back('{32'h20000000,
      mk(2'b00, 6'h20, 11'b00000001100), 1'b0});

    clk       = 1'b0;
    reset     = 1'b1;
    bus.stall = 1'b0;
    bus.instr = 32'h8C000000;

    step();
    check("reset", E_NOP, 1'b0);

    @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_hold", E_NOP, 1'b0);
    step();
    check("lw_after_reset", e_lw, 1'b0);

    @(negedge clk);
    bus.instr = 32'h10000000;
    #1;
    check("latency_pre_edge", e_lw, 1'b0);
    step();
    check("beq_load", e_beq, 1'b0);

    @(negedge clk);
    bus.stall = 1'b1;
    bus.instr = 32'h8C000000;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("stall_hold%0d", i),
            e_beq, 1'b0);
    end

    @(negedge clk);
    bus.stall = 1'b0;
    step();
    check("stall_release", e_lw, 1'b0);

    @(negedge clk);
    bus.stall = 1'b1;
    reset     = 1'b1;
    step();
    check("reset_over_stall", E_NOP, 1'b0);

    @(negedge clk);
    reset     = 1'b0;
    bus.stall = 1'b0;
    step();
    check("lw_after_reset2", e_lw, 1'b0);

    for (int i = 0; i < vt.size(); i++) begin
      @(negedge clk);
      bus.instr = vt[i].instr;
      step();
      check($sformatf("vec%0d_%08h", i, vt[i].instr),
            vt[i].exp, vt[i].ill);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Main decoder for the single-issue MIPS-subset datapath.
- Decodes a 32-bit instruction word into ALU operation selects and datapath control strobes.
- Outputs are registered, with one cycle of latency, so they align with the pipeline register that follows instruction fetch.
- Sits between the instruction memory/IF stage and the register file, ALU, data memory, branch/jump logic and syscall unit.

Parameters:
- none (all encodings are fixed constants in the shared package)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- stall  input  1  when high, all registered outputs hold their value
- instr  input  32  instruction word; opcode = instr[31:26], funct = instr[5:0]
- ALUOp  output  2  ALU class: 00 add, 01 sub/compare, 10 R-type (use func), 11 logical-immediate
- func  output  6  effective ALU function code
- RegDST  output  1  1 = write rd, 0 = write rt
- BEQ  output  1  branch-if-equal
- BNE  output  1  branch-if-not-equal
- JMP  output  1  unconditional jump (j, jal, jr)
- MemRead  output  1  data memory read
- MemtoReg  output  1  write-back selects memory data
- MemWrite  output  1  data memory write
- ALUSrc  output  1  ALU operand B = immediate
- RegWrite  output  1  register file write enable
- LUI  output  1  write-back selects {imm,16'h0}
- SysEnable  output  1  syscall strobe

Behaviour:
- Clocking and reset:
  - Clock/reset are one clock, synchronous active-high reset.
  - Reset forces every output to 0 (NOP state); reset has priority over stall.
  - Otherwise, on each rising edge with stall=0, outputs <= decode(instr); with stall=1, outputs hold.
  - Latency: instr applied before edge N is visible after edge N.
- Default decode: all outputs 0 unless listed below.
- Opcode 0x00 (R-type):
  - Common settings: ALUOp=10, func=instr[5:0], RegDST=1.
  - funct 0x20 add, 0x22 sub, 0x25 or, 0x2A slt, 0x10 mfhi, 0x12 mflo: RegWrite=1.
  - funct 0x18 mult, 0x1A div: RegWrite=0 (HI/LO written by the ALU).
  - funct 0x08 jr: JMP=1, RegWrite=0, RegDST=0.
  - funct 0x0C syscall: SysEnable=1, RegWrite=0, RegDST=0.
  - instr==32'h0 (NOP): all outputs 0, including ALUOp and func.
  - Any other funct: treated as NOP (all 0).
- I-type and J-type opcodes:
  - 0x04 beq: BEQ=1, ALUOp=01, func=0x22.
  - 0x05 bne: BNE=1, ALUOp=01, func=0x22.
  - 0x23 lw: MemRead=1, MemtoReg=1, ALUSrc=1, RegWrite=1, ALUOp=00, func=0x20.
  - 0x2B and 0x25 sw: both opcodes decode as store. MemWrite=1, ALUSrc=1, ALUOp=00, func=0x20.
  - 0x0F lui: LUI=1, RegWrite=1, ALUSrc=1, ALUOp=11, func=0x25.
  - 0x0D ori: RegWrite=1, ALUSrc=1, ALUOp=11, func=0x25.
  - 0x08 addi: RegWrite=1, ALUSrc=1, ALUOp=00, func=0x20.
  - 0x02 j: JMP=1.
  - 0x03 jal: JMP=1, RegWrite=1 (link register selected externally).
  - Unknown opcode: NOP (all 0).
- Invariants:
  - At most one of BEQ/BNE/JMP is high.
  - MemRead and MemWrite are never both high.
  - SysEnable implies RegWrite=0.
- Only the opcode and funct fields affect decode. rs/rt/rd/shamt/immediate bits are ignored, except that the NOP check uses the full word.

Optional Feature:
- Macro CONTROL_ILLEGAL_EN.
- Defined: adds output port illegal (1 bit), registered like the other outputs. It is set to 1 for an unknown opcode or an unknown R-type funct, and cleared by reset. The other outputs still decode to NOP.
- Undefined: port absent; unknown encodings are silently NOP.

Decomposition:
- Package control_pkg holds:
  - opcode and funct localparams
  - ALUOp encodings (ALU_ADD, ALU_SUB, ALU_RTYPE, ALU_LOGI)
  - a packed struct typedef ctrl_t bundling all outputs
  - a CTRL_NOP constant
- Sub-module control_decode: purely combinational, instr -> ctrl_t.
- control_unit: register stage with reset/stall, unpacking ctrl_t onto the ports.

Test Plan:
- Reset: reset=1 with instr=0x8C000000, one edge -> all outputs 0; release reset -> next edge lw decode (MemRead=1, MemtoReg=1, ALUSrc=1, RegWrite=1, func=0x20).
- Branch/jump sweep:
  - 0x10000000 -> BEQ=1, ALUOp=01, func=0x22.
  - 0x14000000 -> BNE=1.
  - 0x08000000 -> JMP=1.
  - 0x0C000000 -> JMP=1, RegWrite=1.
  - 0x00000008 -> JMP=1, RegWrite=0, ALUOp=10.
- Immediate sweep:
  - 0x3C000000 -> LUI=1, RegWrite=1, ALUSrc=1, ALUOp=11.
  - 0x34000000 -> ALUOp=11, func=0x25.
  - 0x20000000 -> ALUOp=00, func=0x20.
  - 0x94000000 and 0xAC000000 -> MemWrite=1, RegWrite=0.
- R-type sweep:
  - 0x20, 0x22, 0x2A, 0x10, 0x12 -> RegDST=1, RegWrite=1, func echoed.
  - 0x18, 0x1A -> RegWrite=0.
  - 0x0000000C -> SysEnable=1, RegWrite=0.
  - 0x00000000 -> all 0.
- Stall: load beq, then stall=1 while instr=0x8C000000 for 3 edges -> BEQ stays 1 and MemRead stays 0; drop stall -> lw decode after the next edge.
- Illegal (with CONTROL_ILLEGAL_EN): instr=0xFC000000 -> illegal=1, others 0; instr=0x0000003F -> illegal=1; next valid instruction -> illegal=0.
